multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Multi-cycle 32-bit ALU that consumes the 4-bit `ALUOperation` code produced by the ALU control unit and returns a registered result with a start/done handshake. It replaces the combinational ALU in the multicycle datapath. Logic ops and arithmetic complete in one cycle. SLL/SRL run on an iterative 1-bit-per-cycle shifter, so the control FSM must wait on `done`.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. The shift-count width is fixed at 5.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request. Sampled only while `busy`=0.
- `ALUOperation`, input, 4: operation code, captured with `start`.
- `A`, input, 32: operand A (rs), captured with `start`.
- `B`, input, 32: operand B (rt or immediate), captured with `start`.
- `shamt`, input, 5: shift amount, captured with `start`.
- `busy`, output, 1: high from the cycle after an accepted start until the cycle after `done`.
- `done`, output, 1: one-cycle pulse. `ALUResult` and `Zero` are valid on this cycle.
- `ALUResult`, output, 32: registered result.
- `Zero`, output, 1: registered, (`ALUResult` == 0).
- `Illegal`, output, 1: registered. Set with `done` when the code is undefined.

## Operation
Code map:
- 0000 ADD: A+B.
- 0001 SUB: A−B.
- 0010 OR: A|B.
- 0011 AND: A&B.
- 0100 LUI: {B[15:0], 16'h0000}.
- 0101 NOR: ~(A|B).
- 0110 SLL: B << shamt.
- 0111 SRL: B >> shamt (logical).
- 1000 CMP: A−B. Used for BEQ/BNE via `Zero`.
- 1001 JR: A passed through.
- 1010–1111: result 0, `Illegal`=1.

Arithmetic rules:
- Add and subtract are modulo 2^32. No overflow or carry output.
- SUB and CMP produce identical results.

States:
- IDLE: `busy`=0, `done`=0.
  - Accepting `start` latches the code and operands.
  - Non-shift op: compute the result, go to DONE.
  - Shift with `shamt`=0: result = B, go to DONE.
  - Shift with `shamt`>0: load B into the shift register and `shamt` into a down-counter, go to SHIFT.
- SHIFT: `busy`=1.
  - Each cycle: shift register shifts 1 bit (left for SLL, right with zero fill for SRL); counter decrements.
  - When the counter reaches 1 this cycle: write the final value to `ALUResult`, go to DONE.
- DONE: `busy`=1, `done`=1 for exactly one cycle, then IDLE.

Boundary rules:
- `start` in SHIFT or DONE is ignored. There is no queueing.
- Input changes after acceptance have no effect.
- `ALUResult`, `Zero` and `Illegal` hold their values until the next accepted operation reaches DONE.
- The code is decoded from the latched copy. An illegal code still completes through DONE with latency 1.
- `reset` mid-operation aborts it immediately: state IDLE, no `done` is produced.

Reset values (all outputs):
- State IDLE.
- `busy`=0, `done`=0.
- `ALUResult`=0, `Zero`=1, `Illegal`=0.
- Counter and shift register = 0.

## Timing
- Start accepted at rising edge k.
- Non-shift, or shift with `shamt`=0: `done`=1 in cycle k+1, `busy`=1 in cycle k+1 only.
- Shift with `shamt`=n (1..31): SHIFT occupies cycles k+1..k+n, `done`=1 in cycle k+n+1. Worst case is 32 cycles, for n=31.
- Earliest next acceptance is the edge ending the `done` cycle plus one, i.e. when `busy` returns to 0.
  - Back-to-back non-shift throughput: one op every 2 cycles.
- `Zero` and `Illegal` update on the same edge as `ALUResult`.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> immediately `busy`=0, `done`=0, `ALUResult`=0, `Zero`=1, `Illegal`=0.
- ADD: A=32'hFFFF_FFFF, B=1, code 0000 -> `done` at k+1 with `ALUResult`=0, `Zero`=1. Then SUB with A=5, B=7 -> 32'hFFFF_FFFE, `Zero`=0.
- Logic and LUI:
  - OR A=32'hF0F0_0000, B=32'h0000_0F0F -> 32'hF0F0_0F0F.
  - NOR of the same operands -> 32'h0F0F_F0F0.
  - LUI B=32'h1234_ABCD -> 32'hABCD_0000.
- Shifts:
  - SLL B=1, shamt=31 -> `done` exactly at k+32, result 32'h8000_0000.
  - SRL B=32'h8000_0000, shamt=4 -> `done` at k+5, result 32'h0800_0000.
  - SLL with shamt=0 -> `done` at k+1, result = B.
- Handshake: pulse `start` with new operands during SHIFT and during DONE -> both ignored, the original result is unchanged. Then `start` with CMP A=B=32'h55 -> `Zero`=1.
- Illegal and abort:
  - Code 1100 -> `done` at k+1, `ALUResult`=0, `Illegal`=1.
  - SLL shamt=20 with `reset` at k+8 -> no `done` is ever produced.
  - JR A=32'h0040_0010 after the reset -> result 32'h0040_0010.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU for the multicycle datapath.
// Logic and arithmetic ops finish one cycle after start. SLL/SRL run on an
// iterative 1-bit-per-cycle shifter, so the caller must wait for done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; busy=0
// S_SHIFT | iterative shift in progress, one bit per cycle
// S_DONE  | result valid, done pulse; returns to S_IDLE next cycle
module multicycle_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            ALUOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            shamt,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  Illegal
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_LUI = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_JR  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  ill_q, ill_d;

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  is_shift;
    logic                  is_illegal;

    // Single-cycle result from the operands presented with start; it is
    // written into the result register on the accepting edge, which is the
    // same edge that latches the code, so later input changes cannot leak in.
    // Shift codes yield B here, which is the correct answer for shamt=0.
    always_comb begin
        alu_res = '0;
        case (ALUOperation)
            OP_ADD:         alu_res = A + B;
            OP_SUB, OP_CMP: alu_res = A - B;
            OP_OR:          alu_res = A | B;
            OP_AND:         alu_res = A & B;
            OP_LUI:         alu_res = {B[15:0], {(DATA_WIDTH-16){1'b0}}};
            OP_NOR:         alu_res = ~(A | B);
            OP_SLL, OP_SRL: alu_res = B;
            OP_JR:          alu_res = A;
            default:        alu_res = '0;
        endcase
    end

    assign is_shift   = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
    assign is_illegal = (ALUOperation >= 4'b1010);

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = ALUOperation;
                    if (is_shift && (shamt != 5'd0)) begin
                        sh_d    = B;
                        cnt_d   = shamt;
                        state_d = S_SHIFT;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        ill_d   = is_illegal;
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                sh_d  = (op_q == OP_SLL) ? (sh_q << 1) : (sh_q >> 1);
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    res_d   = sh_d;
                    zero_d  = (sh_d == '0);
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            sh_q    <= '0;
            cnt_q   <= 5'd0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign Illegal   = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu with hand-computed expectations.
module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    int checks = 0;
    int errors = 0;

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .Illegal      (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with busy=0; returns #1 after the edge on
    // which done is seen (or the budget expires). lat counts cycles after
    // the accepting edge.
    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_z,
                          input logic exp_ill);
        int lat;
        ALUOperation = op; A = a; B = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; B = ~b; shamt = ~sh; ALUOperation = ~op;
        lat = 1;
        wait_done(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, ALUResult, exp_res);
        chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp_z});
        chk({tag, "_ill"}, {31'd0, Illegal}, {31'd0, exp_ill});
        chk({tag, "_busy_on_done"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        chk({tag, "_res_hold"}, ALUResult, exp_res);
    endtask

    initial begin
        int lat;
        int ndone;
        reset = 1'b1; start = 1'b0; ALUOperation = 4'd0; A = '0; B = '0; shamt = '0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", ALUResult, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        chk("rst_ill", {31'd0, Illegal}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add",   4'b0000, 32'hFFFF_FFFF, 32'h1,         5'd0,  1,  32'h0,         1'b1, 1'b0);
        run_op("sub",   4'b0001, 32'h5,         32'h7,         5'd0,  1,  32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("or",    4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0,  1,  32'hF0F0_0F0F, 1'b0, 1'b0);
        run_op("nor",   4'b0101, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0,  1,  32'h0F0F_F0F0, 1'b0, 1'b0);
        run_op("and",   4'b0011, 32'hF0F0_0000, 32'hFFFF_0000, 5'd0,  1,  32'hF0F0_0000, 1'b0, 1'b0);
        run_op("lui",   4'b0100, 32'h0,         32'h1234_ABCD, 5'd0,  1,  32'hABCD_0000, 1'b0, 1'b0);
        run_op("sll31", 4'b0110, 32'h0,         32'h1,         5'd31, 32, 32'h8000_0000, 1'b0, 1'b0);
        run_op("srl4",  4'b0111, 32'h0,         32'h8000_0000, 5'd4,  5,  32'h0800_0000, 1'b0, 1'b0);
        run_op("sll0",  4'b0110, 32'h0,         32'hDEAD_BEEF, 5'd0,  1,  32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op("srl1",  4'b0111, 32'h0,         32'h3,         5'd1,  2,  32'h1,         1'b0, 1'b0);
        run_op("srl_z", 4'b0111, 32'h0,         32'h1,         5'd1,  2,  32'h0,         1'b1, 1'b0);

        // Start pulses during SHIFT and during DONE must both be ignored.
        ALUOperation = 4'b0110; A = 32'h0; B = 32'h3; shamt = 5'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        ALUOperation = 4'b0000; A = 32'h1; B = 32'h1; shamt = 5'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        wait_done(lat);
        chk("hs_lat", lat, 6);
        chk("hs_res", ALUResult, 32'h60);
        ALUOperation = 4'b0000; A = 32'h9; B = 32'h9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hs_busy_after", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        chk("hs_no_done", ndone, 0);
        chk("hs_res_hold", ALUResult, 32'h60);

        run_op("cmp",   4'b1000, 32'h55,        32'h55,        5'd0,  1,  32'h0,         1'b1, 1'b0);
        run_op("ill",   4'b1100, 32'h1234,      32'h5678,      5'd0,  1,  32'h0,         1'b1, 1'b1);

        // Abort a long shift with an asynchronous mid-cycle reset.
        ALUOperation = 4'b0110; A = 32'h0; B = 32'h1; shamt = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
        end
        #3;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_res", ALUResult, 32'd0);
        chk("abort_zero", {31'd0, Zero}, 32'd1);
        chk("abort_ill", {31'd0, Illegal}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", ndone, 0);

        run_op("jr",    4'b1001, 32'h0040_0010, 32'hFFFF_FFFF, 5'd3,  1,  32'h0040_0010, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
